clk_div_prog: RTL
=================

# clk_div_prog

Runtime-programmable clock divider that generates a registered divided clock enable/clock `clk_out` and a single-cycle `tick` strobe from the system clock. Divide ratio and high-phase length are set through a shadow-register load interface. New settings take effect only at a period boundary, so `clk_out` never glitches or produces a runt pulse. It is the general replacement for the fixed divide-by-4 divider used for slow peripheral timing.

## Interface
- `CNT_W`, 8: width of divisor, high-count and internal counter.
- `DEF_DIV`, 4: divisor loaded at reset. Must be ≥2.
- `DEF_HIGH`, 2: high-phase cycles loaded at reset. Must satisfy 1 ≤ `DEF_HIGH` ≤ `DEF_DIV`−1.

Ports:
- `clk` input 1: system clock. All logic on rising edge.
- `reset` input 1: asynchronous, active-high reset.
- `en` input 1: run enable.
- `load` input 1: single-cycle request to capture `div_val`/`high_val`.
- `div_val` input `CNT_W`: requested period in `clk` cycles.
- `high_val` input `CNT_W`: requested number of high cycles per period.
- `clk_out` output 1: registered divided clock.
- `tick` output 1: one-`clk` pulse in the first cycle of each high phase.
- `pending` output 1: a loaded setting is waiting for the next boundary.
- `cur_div` output `CNT_W`: active divisor, after clamping.
- `cur_high` output `CNT_W`: active high count, after clamping.

## Operation
- Registers:
  - active pair `D`/`H` (drive `cur_div`/`cur_high`)
  - shadow pair `SD`/`SH`
  - counter `cnt`
  - `pending`, `clk_out`, `tick`
- Reset values, applied asynchronously while `reset` is high:
  - `D`=`SD`=`DEF_DIV`
  - `H`=`SH`=`DEF_HIGH`
  - `cnt`=0, `clk_out`=0, `tick`=0, `pending`=0
- Clamping is applied at `load` capture:
  - `SD` = max(`div_val`, 2)
  - `SH` = min(max(`high_val`, 1), `SD`−1)
  - Active values therefore always satisfy 2 ≤ `D` and 1 ≤ `H` ≤ `D`−1.
- Load:
  - `load`=1 captures the clamped values into `SD`/`SH` and sets `pending`=1.
  - A load while `pending` is already 1 overwrites the shadow; last load wins.
- Enabled run (`en`=1), on each edge:
  - `clk_out` ← (`cnt` < `H`)
  - `tick` ← (`cnt` == 0)
  - If `cnt` == `D`−1: `cnt` ← 0. If `pending`, then `D`←`SD`, `H`←`SH`, `pending`←0. This is the period boundary.
  - Otherwise `cnt` ← `cnt`+1.
- Disabled (`en`=0), on each edge:
  - `cnt`←0, `clk_out`←0, `tick`←0.
  - If `pending`, apply the shadow to the active pair immediately and clear `pending`.
  - A high phase may be truncated by deassertion. This is permitted; no partial-pulse stretching.
- Simultaneous `load` and boundary, in the same edge:
  - The previous shadow, if pending, is applied to the active pair.
  - The newly captured value becomes the shadow with `pending`=1.
  - The new value takes effect at the following boundary.
- Simultaneous `load` and `en`=0: the new value is captured into the shadow, and `pending` stays 1. It is applied on the next disabled edge.
- Arithmetic:
  - `cnt` is unsigned `CNT_W` bits and never exceeds `D`−1, so it does not wrap.
  - Comparisons are unsigned.

## Timing
- Latency from `en` rising to first `clk_out`=1 is 1 edge.
  - Then `clk_out` is high for exactly `H` cycles and low for `D`−`H` cycles, repeating with period `D`.
- `tick` is high in the same cycle `clk_out` first goes high each period, for exactly 1 cycle.
- Ratio-change latency: the new setting starts with the period that begins right after the current period completes.
  - Worst case is `D`+1 edges from `load`.
  - `pending` reads 1 from the edge after `load` until the edge that applies it.
- `reset` mid-period forces all outputs low immediately, with no wait for a `clk` edge.
  - Run resumes from `cnt`=0 on the first edge after release, if `en`=1.
- `clk_out` is driven directly by a flop: no combinational path from inputs.

## Test plan
- Reset then `en`=1, defaults (4/2):
  - `clk_out` pattern 1,1,0,0 repeating from edge 1.
  - `tick` high on edges 1, 5, 9, …
  - `cur_div`=4, `cur_high`=2.
- `load` with `div_val`=7, `high_val`=3 mid-period:
  - Current 4-cycle period completes unchanged, with `pending`=1 during the wait.
  - Then 3 high / 4 low, and `pending` clears at the boundary.
- Clamping:
  - `load` 0/0 → `cur_div`=2, `cur_high`=1, giving a 1/1 toggle.
  - `load` 5/9 → `cur_high`=4.
- `load` coincident with boundary while a prior load is pending:
  - Prior values are applied at that boundary.
  - New values are applied exactly one period later.
- `en` dropped during the high phase:
  - `clk_out` is 0 the next edge and stays 0 while disabled.
  - A pending load is applied while disabled.
  - Re-enable produces a full `H`-cycle high phase starting at edge 1.
- `reset` asserted asynchronously mid-high-phase with `pending`=1:
  - `clk_out`, `tick` and `pending` go 0 at once.
  - `cur_div`/`cur_high` return to `DEF_DIV`/`DEF_HIGH`.

Source files
------------

// File: rtl/clk_div_prog_if.sv
// Control/status bundle for clk_div_prog: run enable, shadow-load request and settings,
// plus the divided clock, tick strobe and the active (clamped) settings.
interface clk_div_prog_if #(
  parameter int CNT_W = 8
);
  logic             en;
  logic             load;
  logic [CNT_W-1:0] div_val;
  logic [CNT_W-1:0] high_val;
  logic             clk_out;
  logic             tick;
  logic             pending;
  logic [CNT_W-1:0] cur_div;
  logic [CNT_W-1:0] cur_high;

  modport master (
    output en, load, div_val, high_val,
    input  clk_out, tick, pending, cur_div, cur_high
  );

  modport slave (
    input  en, load, div_val, high_val,
    output clk_out, tick, pending, cur_div, cur_high
  );
endinterface

// File: rtl/clk_div_prog.sv
// Programmable clock divider: registered clk_out/tick with glitch-free ratio changes.
// New settings sit in a shadow pair and are applied only at a period boundary or while disabled.
module clk_div_prog #(
  parameter int CNT_W    = 8,
  parameter int DEF_DIV  = 4,
  parameter int DEF_HIGH = 2
) (
  input  logic         clk,
  input  logic         reset,
  clk_div_prog_if.slave bus
);

  localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);
  localparam logic [CNT_W-1:0] TWO      = CNT_W'(2);
  localparam logic [CNT_W-1:0] DEF_D    = CNT_W'(DEF_DIV);
  localparam logic [CNT_W-1:0] DEF_H    = CNT_W'(DEF_HIGH);

  logic [CNT_W-1:0] div_q,  div_d;
  logic [CNT_W-1:0] high_q, high_d;
  logic [CNT_W-1:0] sdiv_q, sdiv_d;
  logic [CNT_W-1:0] shigh_q, shigh_d;
  logic [CNT_W-1:0] cnt_q,  cnt_d;
  logic             pend_q, pend_d;
  logic             clk_out_q, clk_out_d;
  logic             tick_q, tick_d;

  logic [CNT_W-1:0] div_clamp;
  logic [CNT_W-1:0] high_floor;
  logic [CNT_W-1:0] high_clamp;
  logic             boundary;

  // Clamp at capture so the active pair always holds 2 <= D and 1 <= H <= D-1.
  always_comb begin
    div_clamp  = (bus.div_val < TWO) ? TWO : bus.div_val;
    high_floor = (bus.high_val == '0) ? ONE : bus.high_val;
    high_clamp = (high_floor > (div_clamp - ONE)) ? (div_clamp - ONE) : high_floor;
  end

  assign boundary = (cnt_q == (div_q - ONE));

  always_comb begin
    div_d     = div_q;
    high_d    = high_q;
    sdiv_d    = sdiv_q;
    shigh_d   = shigh_q;
    cnt_d     = cnt_q;
    pend_d    = pend_q;
    clk_out_d = clk_out_q;
    tick_d    = tick_q;

    if (bus.en) begin
      clk_out_d = (cnt_q < high_q);
      tick_d    = (cnt_q == '0);
      if (boundary) begin
        cnt_d = '0;
        if (pend_q) begin
          div_d  = sdiv_q;
          high_d = shigh_q;
          pend_d = 1'b0;
        end
      end else begin
        cnt_d = cnt_q + ONE;
      end
    end else begin
      cnt_d     = '0;
      clk_out_d = 1'b0;
      tick_d    = 1'b0;
      if (pend_q) begin
        div_d  = sdiv_q;
        high_d = shigh_q;
        pend_d = 1'b0;
      end
    end

    // A same-edge load lands in the shadow after the old shadow was consumed above.
    if (bus.load) begin
      sdiv_d  = div_clamp;
      shigh_d = high_clamp;
      pend_d  = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div_q     <= DEF_D;
      high_q    <= DEF_H;
      sdiv_q    <= DEF_D;
      shigh_q   <= DEF_H;
      cnt_q     <= '0;
      pend_q    <= 1'b0;
      clk_out_q <= 1'b0;
      tick_q    <= 1'b0;
    end else begin
      div_q     <= div_d;
      high_q    <= high_d;
      sdiv_q    <= sdiv_d;
      shigh_q   <= shigh_d;
      cnt_q     <= cnt_d;
      pend_q    <= pend_d;
      clk_out_q <= clk_out_d;
      tick_q    <= tick_d;
    end
  end

  assign bus.clk_out  = clk_out_q;
  assign bus.tick     = tick_q;
  assign bus.pending  = pend_q;
  assign bus.cur_div  = div_q;
  assign bus.cur_high = high_q;

endmodule
